// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the decode stage.
// Builds the sign/zero-extended immediate for the RV32/RV64 base formats,
// the CSR zimm form and the shift amount. The result sits behind a two-entry
// skid buffer (main = output register, skid = overflow register), so
// in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int TAG_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                imm_src,
    input  logic [31:0]               instr,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BUS_WIDTH-1:0] out_imm,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam bit IS_64 = (DATA_BUS_WIDTH == 64);

    logic [1:0]                r_state;
    logic [DATA_BUS_WIDTH-1:0] r_main_imm;
    logic [TAG_WIDTH-1:0]      r_main_tag;
    logic                      r_main_ill;
    logic [DATA_BUS_WIDTH-1:0] r_skid_imm;
    logic [TAG_WIDTH-1:0]      r_skid_tag;
    logic                      r_skid_ill;

    logic [31:0]               w_imm32;
    logic                      w_illegal;
    logic [DATA_BUS_WIDTH-1:0] w_imm_ext;
    logic                      w_in_xfer;
    logic                      w_out_xfer;
    logic                      w_load_main_new;
    logic                      w_load_main_skid;
    logic                      w_load_skid;
    logic                      w_unused_opcode;

    // The opcode field never contributes to any immediate.
    assign w_unused_opcode = ^instr[6:0];

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missed case arm infers a latch.
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (imm_src)
            3'b000: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            3'b011: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            3'b100: w_imm32 = {instr[31:12], 12'b0};
            3'b101: w_imm32 = {27'b0, instr[19:15]};
            3'b110: begin
                if (IS_64) w_imm32 = {26'b0, instr[25:20]};
                else       w_imm32 = {27'b0, instr[24:20]};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // The zero-extended forms (zimm, shamt, reserved) always have bit 31
    // clear, so one sign extension from bit 31 covers every format.
    generate
        if (IS_64) begin : g_ext64
            assign w_imm_ext = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_ext32
            assign w_imm_ext = w_imm32;
        end
    endgenerate

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    assign w_load_main_new  = w_in_xfer &&
                              ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && w_out_xfer));
    assign w_load_main_skid = (r_state == ST_TWO) && w_out_xfer;
    assign w_load_skid      = (r_state == ST_ONE) && w_in_xfer && !w_out_xfer;

    // Buffer occupancy: EMPTY -> ONE -> TWO and back; flush empties it.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_xfer) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      r_state <= ST_TWO;
                    else if (!w_in_xfer && w_out_xfer) r_state <= ST_EMPTY;
                end
                ST_TWO:   if (w_out_xfer) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Main (output) register: loads a fresh entry or promotes the skid entry.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the payload registers are reset too so out_tag reads zero out
        // of reset; validity itself is tracked only by r_state.
        if (rst) begin
            r_main_imm <= '0;
            r_main_tag <= '0;
            r_main_ill <= 1'b0;
        end else if (w_load_main_new) begin
            r_main_imm <= w_imm_ext;
            r_main_tag <= in_tag;
            r_main_ill <= w_illegal;
        end else if (w_load_main_skid) begin
            r_main_imm <= r_skid_imm;
            r_main_tag <= r_skid_tag;
            r_main_ill <= r_skid_ill;
        end
    end

    // Skid register: catches the entry accepted while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_ill <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_imm_ext;
            r_skid_tag <= in_tag;
            r_skid_ill <= w_illegal;
        end
    end

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready    = (r_state != ST_TWO);
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_imm     = out_valid ? r_main_imm : '0;
    assign out_tag     = r_main_tag;
    assign out_illegal = out_valid & r_main_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: a 32-bit and a 64-bit instance share one
// stimulus stream; each has its own expected-result queue.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  imm_src;
    logic [31:0] instr;
    logic [31:0] in_tag;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32, out_tag32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    exp_t q32[$];
    exp_t q64[$];

    int n_checks = 0;
    int n_errors = 0;

    imm_gen_pipe #(.DATA_BUS_WIDTH(32), .TAG_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .imm_src(imm_src), .instr(instr), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_ill32)
    );

    imm_gen_pipe #(.DATA_BUS_WIDTH(64), .TAG_WIDTH(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .imm_src(imm_src), .instr(instr), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate, written field by field from the format table.
    function automatic exp_t model(input logic [31:0] i, input logic [2:0] src,
                                   input logic [31:0] tag, input bit is64);
        exp_t        e;
        logic [31:0] v;
        bit          zext;
        zext = 1'b0;
        e.ill = 1'b0;
        case (src)
            3'd0: v = {{20{i[31]}}, i[31:20]};
            3'd1: v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: v = {i[31:12], 12'h000};
            3'd5: begin v = {27'd0, i[19:15]}; zext = 1'b1; end
            3'd6: begin v = is64 ? {26'd0, i[25:20]} : {27'd0, i[24:20]}; zext = 1'b1; end
            default: begin v = 32'd0; zext = 1'b1; e.ill = 1'b1; end
        endcase
        e.imm = (zext || !is64) ? {32'd0, v} : {{32{v[31]}}, v};
        e.tag = tag;
        return e;
    endfunction

    // Scoreboard sample at the falling edge: outputs leaving at the next
    // rising edge are compared, then the accepted input (if any) is queued.
    task automatic sb_sample();
        exp_t e;
        if (rst) return;
        if (out_valid32 && out_ready) begin
            n_checks++;
            if (q32.size() == 0) begin
                n_errors++;
                $display("FAIL sb32_unexpected: got imm=%h tag=%h, expected no output", out_imm32, out_tag32);
            end else begin
                e = q32.pop_front();
                if (out_imm32 !== e.imm[31:0] || out_tag32 !== e.tag || out_ill32 !== e.ill) begin
                    n_errors++;
                    $display("FAIL sb32_entry: got imm=%h tag=%h ill=%b, expected imm=%h tag=%h ill=%b",
                             out_imm32, out_tag32, out_ill32, e.imm[31:0], e.tag, e.ill);
                end
            end
        end
        if (out_valid64 && out_ready) begin
            n_checks++;
            if (q64.size() == 0) begin
                n_errors++;
                $display("FAIL sb64_unexpected: got imm=%h tag=%h, expected no output", out_imm64, out_tag64);
            end else begin
                e = q64.pop_front();
                if (out_imm64 !== e.imm || out_tag64 !== e.tag || out_ill64 !== e.ill) begin
                    n_errors++;
                    $display("FAIL sb64_entry: got imm=%h tag=%h ill=%b, expected imm=%h tag=%h ill=%b",
                             out_imm64, out_tag64, out_ill64, e.imm, e.tag, e.ill);
                end
            end
        end
        if (flush) begin
            q32.delete();
            q64.delete();
        end else if (in_valid && in_ready32) begin
            q32.push_back(model(instr, imm_src, in_tag, 1'b0));
            q64.push_back(model(instr, imm_src, in_tag, 1'b1));
        end
    endtask

    // One cycle: scoreboard at the falling edge, then stop 1 after the rising edge.
    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] ins,
                         input logic [31:0] tag);
        in_valid = v;
        imm_src  = src;
        instr    = ins;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        n_checks++;
        if (out_valid32 !== 1'b0 || out_imm32 !== 32'd0 || out_tag32 !== 32'd0 ||
            out_ill32 !== 1'b0 || in_ready32 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset32: got v=%b imm=%h tag=%h ill=%b rdy=%b, expected 0 0 0 0 1",
                     out_valid32, out_imm32, out_tag32, out_ill32, in_ready32);
        end
        n_checks++;
        if (out_valid64 !== 1'b0 || out_imm64 !== 64'd0 || in_ready64 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset64: got v=%b imm=%h rdy=%b, expected 0 0 1",
                     out_valid64, out_imm64, in_ready64);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_i_format();
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'hFFF0_0093, 32'h100);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'hFFFF_FFFF || out_tag32 !== 32'h100) begin
            n_errors++;
            $display("FAIL i_format: got v=%b imm=%h tag=%h, expected 1 ffffffff 00000100",
                     out_valid32, out_imm32, out_tag32);
        end
        step();
        n_checks++;
        if (out_valid32 !== 1'b0 || out_imm32 !== 32'd0) begin
            n_errors++;
            $display("FAIL idle_zero: got v=%b imm=%h, expected 0 00000000", out_valid32, out_imm32);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3] = '{32'hFE20_AE23, 32'hFE00_0CE3, 32'h1234_5037};
        logic [2:0]  src [3] = '{3'd1, 3'd2, 3'd4};
        logic [31:0] exp [3] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h1234_5000};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, src[k], ins[k], 32'h200 + k);
            step();
            n_checks++;
            if (out_valid32 !== 1'b1 || out_imm32 !== exp[k] || in_ready32 !== 1'b1) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: got v=%b imm=%h rdy=%b, expected 1 %h 1",
                         k, out_valid32, out_imm32, in_ready32, exp[k]);
            end
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h0050_0093, 32'h300);
        step();
        n_checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'd5 || in_ready32 !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_first: got v=%b imm=%h rdy=%b, expected 1 00000005 1",
                     out_valid32, out_imm32, in_ready32);
        end
        drive(1'b1, 3'd1, 32'hFE20_AE23, 32'h301);
        step();
        n_checks++;
        if (in_ready32 !== 1'b0 || out_imm32 !== 32'd5) begin
            n_errors++;
            $display("FAIL bp_full: got rdy=%b imm=%h, expected 0 00000005", in_ready32, out_imm32);
        end
        drive(1'b1, 3'd4, 32'h1234_5037, 32'h302);
        step();
        n_checks++;
        if (in_ready32 !== 1'b0 || out_imm32 !== 32'd5 || out_tag32 !== 32'h300) begin
            n_errors++;
            $display("FAIL bp_hold: got rdy=%b imm=%h tag=%h, expected 0 00000005 00000300",
                     in_ready32, out_imm32, out_tag32);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (in_ready32 !== 1'b1 || out_imm32 !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL bp_drain1: got rdy=%b imm=%h, expected 1 fffffffc", in_ready32, out_imm32);
        end
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'h1234_5000) begin
            n_errors++;
            $display("FAIL bp_drain2: got v=%b imm=%h, expected 1 12345000", out_valid32, out_imm32);
        end
        step();
        n_checks++;
        if (out_valid32 !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_empty: got v=%b, expected 0", out_valid32);
        end
    endtask

    task automatic test_wide64();
        logic [31:0] ins [3] = '{32'h8000_0037, 32'h03F0_0013, 32'h000F_8073};
        logic [2:0]  src [3] = '{3'd4, 3'd6, 3'd5};
        logic [63:0] exp [3] = '{64'hFFFF_FFFF_8000_0000, 64'd63, 64'h1F};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, src[k], ins[k], 32'h400 + k);
            step();
            n_checks++;
            if (out_valid64 !== 1'b1 || out_imm64 !== exp[k]) begin
                n_errors++;
                $display("FAIL wide64[%0d]: got v=%b imm=%h, expected 1 %h",
                         k, out_valid64, out_imm64, exp[k]);
            end
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h500);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'd0 || out_ill32 !== 1'b1 ||
            out_imm64 !== 64'd0 || out_ill64 !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal: got v=%b imm32=%h ill32=%b imm64=%h ill64=%b, expected 1 0 1 0 1",
                     out_valid32, out_imm32, out_ill32, out_imm64, out_ill64);
        end
        step();
    endtask

    task automatic test_flush();
        // Flush while holding one entry with a fresh input offered.
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h0010_0093, 32'h600);
        step();
        drive(1'b1, 3'd0, 32'h0020_0093, 32'h601);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_one: got v32=%b v64=%b, expected 0 0", out_valid32, out_valid64);
        end
        // Flush while full with an input offered.
        drive(1'b1, 3'd0, 32'h0030_0093, 32'h602);
        step();
        drive(1'b1, 3'd0, 32'h0040_0093, 32'h603);
        step();
        n_checks++;
        if (in_ready32 !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_setup: got rdy=%b, expected 0", in_ready32);
        end
        drive(1'b1, 3'd0, 32'h0050_0093, 32'h604);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_two: got v32=%b v64=%b rdy=%b, expected 0 0 1",
                     out_valid32, out_valid64, in_ready32);
        end
        out_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (out_valid32 !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_ghost: got v=%b, expected 0", out_valid32);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h0060_0093, 32'h700);
        step();
        drive(1'b1, 3'd0, 32'h0070_0093, 32'h701);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || out_imm32 !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_async: got v32=%b v64=%b rdy=%b imm=%h, expected 0 0 1 00000000",
                     out_valid32, out_valid64, in_ready32, out_imm32);
        end
        q32.delete();
        q64.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got v32=%b v64=%b, expected 0 0", out_valid32, out_valid64);
        end
        drive(1'b1, 3'd3, 32'h0080_006F, 32'h702);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'd8 || out_tag32 !== 32'h702) begin
            n_errors++;
            $display("FAIL reset_latency: got v=%b imm=%h tag=%h, expected 1 00000008 00000702",
                     out_valid32, out_imm32, out_tag32);
        end
        step();
    endtask

    task automatic test_drain_end();
        out_ready = 1'b1;
        repeat (2) step();
        n_checks++;
        if (q32.size() != 0 || q64.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got q32=%0d q64=%0d entries, expected 0 0", q32.size(), q64.size());
        end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_back_to_back();
        test_backpressure();
        test_wide64();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_drain_end();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
